// File: rtl/ws_conv_sequencer.sv
// Weight-stationary convolution sequencer: loads kernel weights and activations into the
// array from XMEM, drains OFIFO psums into PMEM, then re-reads PMEM to accumulate outputs.
module ws_conv_sequencer #(
  parameter int unsigned COL    = 8,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned IN_DIM = 6,
  parameter int unsigned WBASE  = 8'h80,
  parameter int unsigned XAW    = 8,
  parameter int unsigned PAW    = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           l0_ready,
  input  logic           ofifo_valid,
  output logic           xmem_cen,
  output logic           xmem_wen,
  output logic [XAW-1:0] xmem_addr,
  output logic           load,
  output logic           execute,
  output logic           mode,
  output logic           ofifo_rd,
  output logic           pmem_cen,
  output logic           pmem_wen,
  output logic [PAW-1:0] pmem_addr,
  output logic           acc,
  output logic           psum_bypass,
  output logic           busy,
  output logic           done
);

  localparam int unsigned LEN_KIJ  = KSIZE * KSIZE;
  localparam int unsigned LEN_NIJ  = IN_DIM * IN_DIM;
  localparam int unsigned OUT_DIM  = IN_DIM - KSIZE + 1;
  localparam int unsigned TOTAL    = LEN_KIJ * LEN_NIJ;
  localparam int unsigned KIJ_W    = $clog2(LEN_KIJ + 1);
  localparam int unsigned T_W      = $clog2(COL + 1);
  localparam int unsigned NIJ_W    = $clog2(LEN_NIJ + 1);
  localparam int unsigned WR_W     = $clog2(TOTAL + 1);
  localparam int unsigned O_W      = $clog2(OUT_DIM + 1);
  localparam int unsigned KS_W     = $clog2(KSIZE + 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StExec, StDrain, StAcc, StAccGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [KIJ_W-1:0] kij_q, kij_d, k_q, k_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [NIJ_W-1:0] nij_q, nij_d;
  logic [WR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [O_W-1:0]   orow_q, orow_d, ocol_q, ocol_d;
  logic [KS_W-1:0]  krow_q, krow_d, kcol_q, kcol_d;

  logic           xmem_cen_q, xmem_cen_d, xmem_wen_q, xmem_wen_d;
  logic [XAW-1:0] xmem_addr_q, xmem_addr_d;
  logic           load_q, load_d, execute_q, execute_d, mode_q, mode_d, ofifo_rd_q, ofifo_rd_d;
  logic           pmem_cen_q, pmem_cen_d, pmem_wen_q, pmem_wen_d;
  logic [PAW-1:0] pmem_addr_q, pmem_addr_d;
  logic           acc_q, acc_d, psum_bypass_q, psum_bypass_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d     = state_q;
    kij_d       = kij_q;
    k_d         = k_q;
    t_d         = t_q;
    nij_d       = nij_q;
    wr_cnt_d    = wr_cnt_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    krow_d      = krow_q;
    kcol_d      = kcol_q;
    xmem_cen_d  = 1'b1;
    xmem_wen_d  = 1'b1;
    xmem_addr_d = xmem_addr_q;
    load_d      = 1'b0;
    execute_d   = 1'b0;
    mode_d      = 1'b0;
    ofifo_rd_d  = 1'b0;
    pmem_cen_d  = 1'b1;
    pmem_wen_d  = 1'b1;
    pmem_addr_d = pmem_addr_q;
    acc_d       = 1'b0;

    // Drain runs alongside weight/activation streaming; PMEM is otherwise idle until ACC.
    if ((state_q inside {StLoadW, StExec, StDrain}) && ofifo_valid &&
        (wr_cnt_q < WR_W'(TOTAL))) begin
      ofifo_rd_d  = 1'b1;
      pmem_cen_d  = 1'b0;
      pmem_wen_d  = 1'b0;
      pmem_addr_d = PAW'(wr_cnt_q);
      wr_cnt_d    = wr_cnt_q + WR_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoadW;
          kij_d    = '0;
          k_d      = '0;
          t_d      = '0;
          nij_d    = '0;
          wr_cnt_d = '0;
          orow_d   = '0;
          ocol_d   = '0;
          krow_d   = '0;
          kcol_d   = '0;
        end
      end
      StLoadW: begin
        if (l0_ready) begin
          xmem_cen_d  = 1'b0;
          load_d      = 1'b1;
          xmem_addr_d = XAW'(WBASE + 32'(kij_q) * COL + 32'(t_q));
          if (t_q == T_W'(COL - 1)) begin
            t_d     = '0;
            state_d = StExec;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
      end
      StExec: begin
        // nij == LEN_NIJ marks the mode=1 turnaround cycle after the last activation row.
        if (nij_q == NIJ_W'(LEN_NIJ)) begin
          mode_d = 1'b1;
          nij_d  = '0;
          if (kij_q == KIJ_W'(LEN_KIJ - 1)) begin
            state_d = StDrain;
          end else begin
            kij_d   = kij_q + KIJ_W'(1);
            state_d = StLoadW;
          end
        end else if (l0_ready) begin
          xmem_cen_d  = 1'b0;
          execute_d   = 1'b1;
          xmem_addr_d = XAW'(nij_q);
          nij_d       = nij_q + NIJ_W'(1);
        end
      end
      StDrain: begin
        if (wr_cnt_q == WR_W'(TOTAL)) state_d = StAcc;
      end
      StAcc: begin
        pmem_cen_d  = 1'b0;
        acc_d       = 1'b1;
        pmem_addr_d = PAW'(32'(k_q) * LEN_NIJ + (32'(orow_q) + 32'(krow_q)) * IN_DIM +
                           32'(ocol_q) + 32'(kcol_q));
        if (k_q == KIJ_W'(LEN_KIJ - 1)) begin
          k_d     = '0;
          krow_d  = '0;
          kcol_d  = '0;
          state_d = StAccGap;
        end else begin
          k_d = k_q + KIJ_W'(1);
          if (kcol_q == KS_W'(KSIZE - 1)) begin
            kcol_d = '0;
            krow_d = krow_q + KS_W'(1);
          end else begin
            kcol_d = kcol_q + KS_W'(1);
          end
        end
      end
      StAccGap: begin
        state_d = StAcc;
        if (ocol_q == O_W'(OUT_DIM - 1)) begin
          ocol_d = '0;
          if (orow_q == O_W'(OUT_DIM - 1)) begin
            orow_d  = '0;
            state_d = StDone;
          end else begin
            orow_d = orow_q + O_W'(1);
          end
        end else begin
          ocol_d = ocol_q + O_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
    psum_bypass_d = (state_d inside {StLoadW, StExec, StDrain});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      kij_q         <= '0;
      k_q           <= '0;
      t_q           <= '0;
      nij_q         <= '0;
      wr_cnt_q      <= '0;
      orow_q        <= '0;
      ocol_q        <= '0;
      krow_q        <= '0;
      kcol_q        <= '0;
      xmem_cen_q    <= 1'b1;
      xmem_wen_q    <= 1'b1;
      xmem_addr_q   <= '0;
      load_q        <= 1'b0;
      execute_q     <= 1'b0;
      mode_q        <= 1'b0;
      ofifo_rd_q    <= 1'b0;
      pmem_cen_q    <= 1'b1;
      pmem_wen_q    <= 1'b1;
      pmem_addr_q   <= '0;
      acc_q         <= 1'b0;
      psum_bypass_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      kij_q         <= kij_d;
      k_q           <= k_d;
      t_q           <= t_d;
      nij_q         <= nij_d;
      wr_cnt_q      <= wr_cnt_d;
      orow_q        <= orow_d;
      ocol_q        <= ocol_d;
      krow_q        <= krow_d;
      kcol_q        <= kcol_d;
      xmem_cen_q    <= xmem_cen_d;
      xmem_wen_q    <= xmem_wen_d;
      xmem_addr_q   <= xmem_addr_d;
      load_q        <= load_d;
      execute_q     <= execute_d;
      mode_q        <= mode_d;
      ofifo_rd_q    <= ofifo_rd_d;
      pmem_cen_q    <= pmem_cen_d;
      pmem_wen_q    <= pmem_wen_d;
      pmem_addr_q   <= pmem_addr_d;
      acc_q         <= acc_d;
      psum_bypass_q <= psum_bypass_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign xmem_cen    = xmem_cen_q;
  assign xmem_wen    = xmem_wen_q;
  assign xmem_addr   = xmem_addr_q;
  assign load        = load_q;
  assign execute     = execute_q;
  assign mode        = mode_q;
  assign ofifo_rd    = ofifo_rd_q;
  assign pmem_cen    = pmem_cen_q;
  assign pmem_wen    = pmem_wen_q;
  assign pmem_addr   = pmem_addr_q;
  assign acc         = acc_q;
  assign psum_bypass = psum_bypass_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ws_conv_sequencer.sv
// Scoreboard bench for ws_conv_sequencer: default instance checked cycle by cycle against
// expected XMEM/PMEM address streams; a small-kernel instance checked by transaction counts.
module tb_ws_conv_sequencer;

  logic clk, reset, start, l0_ready, ofifo_valid;
  logic d_xmem_cen, d_xmem_wen, d_load, d_execute, d_mode, d_ofifo_rd;
  logic d_pmem_cen, d_pmem_wen, d_acc, d_psum_bypass, d_busy, d_done;
  logic [7:0] d_xmem_addr;
  logic [8:0] d_pmem_addr;

  logic s_start, s_l0_ready, s_ofifo_valid;
  logic s_xmem_cen, s_xmem_wen, s_load, s_execute, s_mode, s_ofifo_rd;
  logic s_pmem_cen, s_pmem_wen, s_acc, s_psum_bypass, s_busy, s_done;
  logic [7:0] s_xmem_addr;
  logic [8:0] s_pmem_addr;

  ws_conv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
    .xmem_cen(d_xmem_cen), .xmem_wen(d_xmem_wen), .xmem_addr(d_xmem_addr), .load(d_load),
    .execute(d_execute), .mode(d_mode), .ofifo_rd(d_ofifo_rd), .pmem_cen(d_pmem_cen),
    .pmem_wen(d_pmem_wen), .pmem_addr(d_pmem_addr), .acc(d_acc),
    .psum_bypass(d_psum_bypass), .busy(d_busy), .done(d_done)
  );

  ws_conv_sequencer #(.COL(4), .KSIZE(2), .IN_DIM(5)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .l0_ready(s_l0_ready),
    .ofifo_valid(s_ofifo_valid), .xmem_cen(s_xmem_cen), .xmem_wen(s_xmem_wen),
    .xmem_addr(s_xmem_addr), .load(s_load), .execute(s_execute), .mode(s_mode),
    .ofifo_rd(s_ofifo_rd), .pmem_cen(s_pmem_cen), .pmem_wen(s_pmem_wen),
    .pmem_addr(s_pmem_addr), .acc(s_acc), .psum_bypass(s_psum_bypass), .busy(s_busy),
    .done(s_done)
  );

  int checks = 0;
  int errors = 0;
  int xq[$];
  int pq[$];
  int aq[$];
  int x_seen, acc_idx, mode_cnt, done_cnt, last_wr, first_x;
  bit mon_en = 0;
  bit l0_prev = 1, ofifo_prev = 1;
  bit [1:0] acc_h;

  logic [28:0] rst_vec;
  assign rst_vec = {d_xmem_cen, d_xmem_wen, d_pmem_cen, d_pmem_wen, d_xmem_addr, d_pmem_addr,
                    d_load, d_execute, d_mode, d_ofifo_rd, d_acc, d_psum_bypass, d_busy, d_done};
  localparam logic [28:0] RST_EXP = {4'hF, 8'h00, 9'h000, 8'h00};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    l0_prev    = l0_ready;
    ofifo_prev = ofifo_valid;
  end

  // Scoreboard monitor for the default instance.
  initial forever begin
    int e;
    @(negedge clk);
    if (mon_en) begin
      if (!d_xmem_cen) begin
        checks++;
        if (xq.size() == 0) begin
          errors++;
          $display("FAIL xmem_extra: got addr %0h, expected no access", d_xmem_addr);
        end else begin
          e = xq.pop_front();
          if (x_seen == 0) first_x = d_xmem_addr;
          x_seen++;
          if ({d_load, d_execute, d_xmem_wen, d_xmem_addr} !== {e[8], ~e[8], 1'b1, e[7:0]}) begin
            errors++;
            $display("FAIL xmem_seq: got load=%b exec=%b wen=%b addr=%0h, expected load=%b addr=%0h",
                     d_load, d_execute, d_xmem_wen, d_xmem_addr, e[8], e[7:0]);
          end
        end
      end else if (d_busy) begin
        checks++;
        if (d_load || d_execute) begin
          errors++;
          $display("FAIL xmem_idle_strobe: got load=%b exec=%b, expected 0 0", d_load, d_execute);
        end
      end
      if (!l0_prev && d_busy) begin
        checks++;
        if (d_xmem_cen !== 1'b1) begin
          errors++;
          $display("FAIL l0_stall_cen: got xmem_cen=%b, expected 1", d_xmem_cen);
        end
      end
      if (d_mode) begin
        mode_cnt++;
        checks++;
        if (d_xmem_cen !== 1'b1) begin
          errors++;
          $display("FAIL mode_cycle: got xmem_cen=%b, expected 1", d_xmem_cen);
        end
      end
      if (!d_pmem_cen && !d_pmem_wen) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL pmem_wr_extra: got addr %0d, expected no write", d_pmem_addr);
        end else begin
          e = pq.pop_front();
          last_wr = d_pmem_addr;
          if ({d_ofifo_rd, d_psum_bypass, ofifo_prev, d_pmem_addr} !== {3'b111, e[8:0]}) begin
            errors++;
            $display("FAIL pmem_wr: got rd=%b byp=%b fifo_valid=%b addr=%0d, expected 1 1 1 %0d",
                     d_ofifo_rd, d_psum_bypass, ofifo_prev, d_pmem_addr, e);
          end
        end
      end
      if (!d_pmem_cen && d_pmem_wen) begin
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL acc_extra: got addr %0d, expected no read", d_pmem_addr);
        end else begin
          e = aq.pop_front();
          if ({d_acc, d_psum_bypass, d_pmem_addr} !== {2'b10, e[8:0]}) begin
            errors++;
            $display("FAIL acc_rd %0d: got acc=%b byp=%b addr=%0d, expected 1 0 %0d",
                     acc_idx, d_acc, d_psum_bypass, d_pmem_addr, e);
          end
          if (acc_idx > 0 && acc_idx % 9 == 0) begin
            checks++;
            if (acc_h !== 2'b10) begin
              errors++;
              $display("FAIL acc_gap %0d: got acc history %b, expected 10", acc_idx, acc_h);
            end
          end
          acc_idx++;
        end
      end
      if (d_done) done_cnt++;
      acc_h = {acc_h[0], d_acc};
    end
  end

  task automatic push_expected();
    for (int kij = 0; kij < 9; kij++) begin
      for (int t = 0; t < 8; t++) xq.push_back(256 | (128 + kij * 8 + t));
      for (int n = 0; n < 36; n++) xq.push_back(n);
    end
    for (int w = 0; w < 324; w++) pq.push_back(w);
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 9; k++)
        aq.push_back(k * 36 + (o / 4) * 6 + o % 4 + (k / 3) * 6 + k % 3);
  endtask

  // Caller must be at posedge+2; start is presented immediately.
  task automatic run_conv(input bit rnd, input bit stall, input bit mid_start,
                          input int abort_at, output bit aborted);
    int stall_left = 0;
    bit stalled = 0;
    xq.delete(); pq.delete(); aq.delete();
    x_seen = 0; acc_idx = 0; mode_cnt = 0; done_cnt = 0; last_wr = -1; first_x = -1;
    acc_h = 2'b00;
    aborted = 0;
    push_expected();
    mon_en = 1;
    start = 1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk); #2;
      start = mid_start && (cyc == 60);
      l0_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && !stalled && x_seen >= 4 * 44) begin
        stalled = 1;
        stall_left = 20;
      end
      ofifo_valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (abort_at > 0 && x_seen >= abort_at) begin
        aborted = 1;
        return;
      end
      if (done_cnt > 0 && !d_busy) break;
    end
    l0_ready = 1;
    ofifo_valid = 1;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL done_count: got %0d pulses, expected 1", done_cnt);
    end
    checks++;
    if ({xq.size(), pq.size(), aq.size()} !== 96'd0) begin
      errors++;
      $display("FAIL leftover: got xmem=%0d pmem=%0d acc=%0d pending, expected 0 0 0",
               xq.size(), pq.size(), aq.size());
    end
    checks++;
    if (mode_cnt !== 9 || last_wr !== 323 || first_x !== 8'h80 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL run_summary: got mode=%0d last_wr=%0d first_x=%0h busy=%b, expected 9 323 80 0",
               mode_cnt, last_wr, first_x, d_busy);
    end
    if (stall) begin
      checks++;
      if (!stalled) begin
        errors++;
        $display("FAIL stall_applied: got 0, expected 1");
      end
    end
    mon_en = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    start = 0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (rst_vec !== RST_EXP) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected %h", rst_vec, RST_EXP);
    end
    start = 1;
    @(posedge clk); #2;
    start = 0;
    checks++;
    if (d_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: got busy=%b, expected 0", d_busy);
    end
    reset = 1;
  endtask

  task automatic test_full();
    bit ab;
    run_conv(0, 0, 1, 0, ab);
  endtask

  task automatic test_random_ready();
    bit ab;
    run_conv(1, 0, 0, 0, ab);
  endtask

  task automatic test_ofifo_stall();
    bit ab;
    run_conv(0, 1, 0, 0, ab);
  endtask

  task automatic test_reset_midrun();
    bit ab;
    run_conv(0, 0, 0, 2 * 44 + 8 + 10, ab);
    checks++;
    if (!ab) begin
      errors++;
      $display("FAIL abort_reached: got 0, expected 1");
    end
    mon_en = 0;
    reset = 0;
    #1;
    checks++;
    if (rst_vec !== RST_EXP) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %h, expected %h", rst_vec, RST_EXP);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({d_done, d_busy} !== 2'b00) begin
        errors++;
        $display("FAIL midrun_no_done: got done=%b busy=%b, expected 0 0", d_done, d_busy);
      end
    end
    @(posedge clk); #2;
    reset = 1;
    run_conv(0, 0, 0, 0, ab);
  endtask

  task automatic test_small();
    int loads = 0, execs = 0, writes = 0, accs = 0, modes = 0, dones = 0, a63 = -1, lw = -1;
    s_start = 1;
    @(posedge clk); #2;
    s_start = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!s_xmem_cen && s_load) loads++;
      if (!s_xmem_cen && s_execute) execs++;
      if (!s_pmem_cen && !s_pmem_wen) begin
        writes++;
        lw = s_pmem_addr;
      end
      if (!s_pmem_cen && s_pmem_wen && s_acc) begin
        if (accs == 63) a63 = s_pmem_addr;
        accs++;
      end
      if (s_mode) modes++;
      if (s_done) dones++;
      if (dones > 0 && !s_busy) break;
    end
    repeat (3) begin
      @(negedge clk);
      if (s_done) dones++;
    end
    checks++;
    if (loads !== 16 || execs !== 100 || modes !== 4) begin
      errors++;
      $display("FAIL small_xmem: got loads=%0d execs=%0d modes=%0d, expected 16 100 4",
               loads, execs, modes);
    end
    checks++;
    if (writes !== 100 || lw !== 99 || accs !== 64) begin
      errors++;
      $display("FAIL small_pmem: got writes=%0d last=%0d accs=%0d, expected 100 99 64",
               writes, lw, accs);
    end
    checks++;
    if (a63 !== 3 * 25 + 24 || dones !== 1) begin
      errors++;
      $display("FAIL small_ic: got addr=%0d dones=%0d, expected 99 1", a63, dones);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    reset = 0; start = 0; l0_ready = 1; ofifo_valid = 1;
    s_start = 0; s_l0_ready = 1; s_ofifo_valid = 1;
    test_reset();
    test_full();
    test_random_ready();
    test_ofifo_stall();
    test_reset_midrun();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_conv_sequencer.md
WS_CONV_SEQUENCER -- requirements
Module: ws_conv_sequencer

Interface
REQ-001 The block SHALL have parameter COL, default 8, meaning the number of array columns, which equals the weight rows loaded per kernel position.
REQ-002 The block SHALL have parameter KSIZE, default 3, meaning the kernel edge; LEN_KIJ = KSIZE*KSIZE.
REQ-003 The block SHALL have parameter IN_DIM, default 6, meaning the input edge; LEN_NIJ = IN_DIM*IN_DIM, OUT_DIM = IN_DIM-KSIZE+1, LEN_ONIJ = OUT_DIM*OUT_DIM.
REQ-004 The block SHALL have parameter WBASE, default 8'h80, meaning the XMEM weight base address.
REQ-005 The block SHALL have parameters XAW, default 8, and PAW, default 9, meaning the XMEM and PMEM address widths.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to run a full convolution; ignored unless in IDLE.
REQ-009 l0_ready  input  1  L0 can accept a row this cycle.
REQ-010 ofifo_valid  input  1  OFIFO holds a complete psum row.
REQ-011 xmem_cen, xmem_wen  output  1 each  XMEM controls, active-low; xmem_wen is always 1 (read only).
REQ-012 xmem_addr  output  XAW  XMEM read address.
REQ-013 load, execute, mode  output  1 each  array instruction bits.
REQ-014 ofifo_rd  output  1  pop OFIFO.
REQ-015 pmem_cen, pmem_wen  output  1 each  PMEM controls, active-low.
REQ-016 pmem_addr  output  PAW  PMEM address.
REQ-017 acc, psum_bypass  output  1 each  SFP accumulate enable and bypass select.
REQ-018 busy, done  output  1 each  busy is high when not in IDLE; done is a one-cycle completion pulse.

Function
REQ-019 The state machine SHALL have the states IDLE, LOAD_W, EXEC, DRAIN, ACC, ACC_GAP and DONE.
REQ-020 In IDLE, start SHALL move the block to LOAD_W with kij=0; the block SHALL assert psum_bypass from LOAD_W through DRAIN.
REQ-021 In LOAD_W, each cycle with l0_ready=1 SHALL issue xmem_cen=0, xmem_addr=WBASE+kij*COL+t and load=1, then increment t; after t=COL-1 the block SHALL move to EXEC.
REQ-022 In EXEC, each cycle with l0_ready=1 SHALL issue xmem_cen=0, xmem_addr=nij and execute=1, for nij from 0 to LEN_NIJ-1.
REQ-023 A cycle with l0_ready=0 in LOAD_W or EXEC SHALL drive xmem_cen=1 with load=execute=0 and SHALL hold the counters.
REQ-024 After the last EXEC row, the block SHALL drive one idle cycle with mode=1 and xmem_cen=1.
REQ-025 After that idle cycle, if kij<LEN_KIJ-1 the block SHALL increment kij and move to LOAD_W; otherwise it SHALL move to DRAIN.
REQ-026 The drain path SHALL run in parallel from LOAD_W until DRAIN exits: while ofifo_valid=1 and wr_cnt<LEN_KIJ*LEN_NIJ, assert ofifo_rd=1, pmem_cen=0, pmem_wen=0 and pmem_addr=wr_cnt, then increment wr_cnt.
REQ-027 The drain path SHALL NOT pop or write PMEM once wr_cnt has reached LEN_KIJ*LEN_NIJ.
REQ-028 DRAIN SHALL move to ACC when wr_cnt equals LEN_KIJ*LEN_NIJ.
REQ-029 In ACC, for each onij from 0 to LEN_ONIJ-1 and k from 0 to LEN_KIJ-1, the block SHALL issue pmem_cen=0, pmem_wen=1, acc=1 and pmem_addr=k*LEN_NIJ+ic.
REQ-030 In ACC, ic SHALL equal (onij/OUT_DIM)*IN_DIM + onij%OUT_DIM + (k/KSIZE)*IN_DIM + k%KSIZE.
REQ-031 After k=LEN_KIJ-1, the block SHALL spend one ACC_GAP cycle with acc=0 and pmem_cen=1.
REQ-032 After ACC_GAP, the block SHALL move to the next onij, or to DONE after the last onij.
REQ-033 ic SHALL be computed with row and column counters, with no divider, and pmem_addr SHALL be truncated to PAW bits.
REQ-034 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-035 start received while busy SHALL be ignored.
REQ-036 mode SHALL be 0 in every cycle other than the REQ-024 idle cycle.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 When reset is low, asynchronously, the block SHALL go to IDLE and clear all counters.
REQ-039 When reset is low, the block SHALL drive xmem_cen=xmem_wen=pmem_cen=pmem_wen=1, xmem_addr=pmem_addr=0, and all other outputs 0.
REQ-040 Reset asserted mid-run SHALL abort the run without a done pulse, and the block SHALL accept start on the first cycle after reset deasserts.

Verification
REQ-041 l0_ready=1 and ofifo_valid=1 throughout, one start -> 9 bursts each of 8 loads at 0x80+8*kij and 36 execs at addresses 0..35; 324 PMEM writes at addresses 0..323; 144 acc reads; exactly one done pulse.
REQ-042 l0_ready toggling at 50 % random -> same address sequence with no gaps or repeats; xmem_cen=1 on every cycle with l0_ready=0.
REQ-043 For onij=5, k=8 -> pmem_addr=309; for onij=15, k=0 -> pmem_addr=21; acc=0 for exactly one cycle between consecutive onij.
REQ-044 ofifo_valid held low for 20 cycles during kij=4 -> wr_cnt stalls, DRAIN waits, and the final PMEM write is still at address 323.
REQ-045 Reset pulsed during EXEC of kij=2 -> outputs return to reset values at once with no done pulse, and a following start restarts at address 0x80.
REQ-046 Instance with KSIZE=2, IN_DIM=5, COL=4 -> 4 kij of 4 loads and 25 execs, 100 PMEM writes, 64 acc reads, with ic for onij=15, k=3 equal to 24.
